mips_multicycle_control: RTL and testbench

Multi-cycle main controller for the MIPS datapath. It sequences fetch, decode, execute, memory and write-back over several cycles, and drives every datapath mux/enable. It also drives the 3-bit `ALUOp` that the ALU control decoder turns into the 4-bit ALU function. It sits between the instruction register (opcode source), the ALU (`Zero` flag) and the unified instruction/data memory (ready handshake).

---
 rtl/mips_multicycle_control_pkg.sv | 99 +++++++++
 rtl/mips_multicycle_control.sv | 165 ++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_control_pkg.sv
// Shared encodings for the MIPS multi-cycle main controller: opcodes,
// ALUOp codes (also consumed by the ALU control decoder), mux selects,
// state encodings and the control-word payload.
package mips_multicycle_control_pkg;

    localparam int unsigned OP_W     = 6;
    localparam int unsigned ALUOP_W  = 3;
    localparam int unsigned STATE_W  = 4;
    localparam int unsigned SEL_W    = 2;

    // Supported opcodes (IR[31:26])
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;

    // ALUOp codes handed to the ALU control decoder
    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b000;
    localparam logic [ALUOP_W-1:0] ALUOP_BEQ   = 3'b001;
    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 3'b010;
    localparam logic [ALUOP_W-1:0] ALUOP_ADDI  = 3'b011;
    localparam logic [ALUOP_W-1:0] ALUOP_SLTI  = 3'b100;
    localparam logic [ALUOP_W-1:0] ALUOP_BNE   = 3'b101;

    // ALU operand B select
    localparam logic [SEL_W-1:0] SRCB_REG     = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;

    // PC source select
    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

    // Controller states; encodings 12..15 are unused
    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11
    } state_e;

    // Full datapath control word
    typedef struct packed {
        logic                 pc_write;
        logic                 iord;
        logic                 mem_read;
        logic                 mem_write;
        logic                 ir_write;
        logic                 mem_to_reg;
        logic                 reg_dst;
        logic                 reg_write;
        logic                 alu_src_a;
        logic [SEL_W-1:0]     alu_src_b;
        logic [SEL_W-1:0]     pc_source;
        logic [ALUOP_W-1:0]   alu_op;
        logic                 instr_done;
        logic                 illegal_op;
    } ctrl_t;

    // Successor of DECODE for a given opcode; unsupported opcodes return to FETCH
    function automatic state_e decode_next(input logic [OP_W-1:0] op);
        state_e nxt;
        case (op)
            OP_LW, OP_SW:     nxt = S_MEM_ADDR;
            OP_RTYPE:         nxt = S_R_EXEC;
            OP_BEQ, OP_BNE:   nxt = S_BRANCH;
            OP_J:             nxt = S_JUMP;
            OP_ADDI, OP_SLTI: nxt = S_I_EXEC;
            default:          nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

    // True for every opcode this controller sequences
    function automatic logic is_legal(input logic [OP_W-1:0] op);
        logic legal;
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE,
            OP_J, OP_ADDI, OP_SLTI: legal = 1'b1;
            default:                legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main controller: sequences fetch/decode/execute/memory/
// write-back and drives every datapath mux and enable. Controls are decoded
// combinationally from the current state (plus MemReady/Zero) so memory
// handshakes and reset take effect in the same cycle.
module mips_multicycle_control
    import mips_multicycle_control_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [OP_W-1:0]     OpCode,
    input  logic                Zero,
    input  logic                MemReady,
    output logic                PCWrite,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [SEL_W-1:0]    ALUSrcB,
    output logic [SEL_W-1:0]    PCSource,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                InstrDone,
    output logic                IllegalOp,
    output logic [STATE_W-1:0]  State
);

    state_e          r_state;
    logic [OP_W-1:0] r_op_q;
    state_e          w_next_state;
    ctrl_t           w_ctrl;
    ctrl_t           w_ctrl_out;

    // State register and opcode latch; opcode captured only while in DECODE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_op_q  <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_DECODE) begin
                r_op_q <= OpCode;
            end
        end
    end

    // Next-state and control-word decode
    always_comb begin
        w_next_state = S_FETCH;
        w_ctrl       = '0;
        case (r_state)
            S_FETCH: begin
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.alu_src_b = SRCB_FOUR;
                w_ctrl.alu_op    = ALUOP_ADD;
                w_ctrl.pc_source = PCSRC_ALU;
                w_ctrl.ir_write  = MemReady;
                w_ctrl.pc_write  = MemReady;
                w_next_state     = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Precompute branch target into ALUOut
                w_ctrl.alu_src_b  = SRCB_IMM_SH2;
                w_ctrl.alu_op     = ALUOP_ADD;
                w_ctrl.illegal_op = ~is_legal(OpCode);
                w_next_state      = decode_next(OpCode);
            end
            S_MEM_ADDR: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = ALUOP_ADD;
                w_next_state     = (r_op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.iord     = 1'b1;
                w_next_state    = MemReady ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.instr_done = 1'b1;
                w_next_state      = S_FETCH;
            end
            S_MEM_WR: begin
                w_ctrl.mem_write  = 1'b1;
                w_ctrl.iord       = 1'b1;
                w_ctrl.instr_done = MemReady;
                w_next_state      = MemReady ? S_FETCH : S_MEM_WR;
            end
            S_R_EXEC: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_REG;
                w_ctrl.alu_op    = ALUOP_RTYPE;
                w_next_state     = S_R_WB;
            end
            S_R_WB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.reg_dst    = 1'b1;
                w_ctrl.instr_done = 1'b1;
                w_next_state      = S_FETCH;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a  = 1'b1;
                w_ctrl.alu_src_b  = SRCB_REG;
                w_ctrl.pc_source  = PCSRC_ALUOUT;
                w_ctrl.instr_done = 1'b1;
                if (r_op_q == OP_BEQ) begin
                    w_ctrl.alu_op   = ALUOP_BEQ;
                    w_ctrl.pc_write = Zero;
                end else begin
                    w_ctrl.alu_op   = ALUOP_BNE;
                    w_ctrl.pc_write = ~Zero;
                end
                w_next_state = S_FETCH;
            end
            S_JUMP: begin
                w_ctrl.pc_source  = PCSRC_JUMP;
                w_ctrl.pc_write   = 1'b1;
                w_ctrl.instr_done = 1'b1;
                w_next_state      = S_FETCH;
            end
            S_I_EXEC: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = (r_op_q == OP_ADDI) ? ALUOP_ADDI : ALUOP_SLTI;
                w_next_state     = S_I_WB;
            end
            S_I_WB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.instr_done = 1'b1;
                w_next_state      = S_FETCH;
            end
            default: begin
                // Unused encodings: idle for one cycle, then recover to FETCH
                w_ctrl       = '0;
                w_next_state = S_FETCH;
            end
        endcase
    end

    // Reset silences every control in the same cycle it is asserted
    always_comb begin
        w_ctrl_out = reset ? '0 : w_ctrl;
    end

    assign PCWrite   = w_ctrl_out.pc_write;
    assign IorD      = w_ctrl_out.iord;
    assign MemRead   = w_ctrl_out.mem_read;
    assign MemWrite  = w_ctrl_out.mem_write;
    assign IRWrite   = w_ctrl_out.ir_write;
    assign MemtoReg  = w_ctrl_out.mem_to_reg;
    assign RegDst    = w_ctrl_out.reg_dst;
    assign RegWrite  = w_ctrl_out.reg_write;
    assign ALUSrcA   = w_ctrl_out.alu_src_a;
    assign ALUSrcB   = w_ctrl_out.alu_src_b;
    assign PCSource  = w_ctrl_out.pc_source;
    assign ALUOp     = w_ctrl_out.alu_op;
    assign InstrDone = w_ctrl_out.instr_done;
    assign IllegalOp = w_ctrl_out.illegal_op;
    assign State     = reset ? STATE_W'(0) : STATE_W'(r_state);

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for the multi-cycle MIPS controller: each driven cycle
// pushes the expected control word; a negedge monitor pops and compares.
module tb_mips_multicycle_control;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_BNE  = 6'b000101;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_SLTI = 6'b001010;
    localparam logic [5:0] T_BAD  = 6'b111111;

    logic       clk;
    logic       reset;
    logic [5:0] OpCode;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic       InstrDone, IllegalOp;
    logic [3:0] State;

    typedef struct {
        logic [21:0] v;
        int          ph;
        int          cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         phase  = 0;
    int         cycno  = 0;
    int         done_seen = 0;
    int         done_exp  = 0;
    logic [5:0] cur_op = '0;

    mips_multicycle_control dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp),
        .InstrDone(InstrDone), .IllegalOp(IllegalOp), .State(State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected control word straight from the per-state output table
    function automatic logic [21:0] model(input logic [3:0] st, input logic rst,
                                          input logic mr, input logic z,
                                          input logic [5:0] dec_op, input logic [5:0] opq);
        logic pcw, iord, mrd, mwr, irw, m2r, rdst, rw, sa, dn, ill;
        logic [1:0] sb, pcs;
        logic [2:0] aop;
        {pcw, iord, mrd, mwr, irw, m2r, rdst, rw, sa, dn, ill} = '0;
        sb = 2'b00; pcs = 2'b00; aop = 3'b000;
        if (rst) return 22'h0;
        case (st)
            4'd0:  begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
            4'd1:  begin
                       sb = 2'b11;
                       ill = !(dec_op == T_R || dec_op == T_LW || dec_op == T_SW ||
                               dec_op == T_BEQ || dec_op == T_BNE || dec_op == T_J ||
                               dec_op == T_ADDI || dec_op == T_SLTI);
                   end
            4'd2:  begin sa = 1; sb = 2'b10; end
            4'd3:  begin mrd = 1; iord = 1; end
            4'd4:  begin rw = 1; m2r = 1; dn = 1; end
            4'd5:  begin mwr = 1; iord = 1; dn = mr; end
            4'd6:  begin sa = 1; aop = 3'b010; end
            4'd7:  begin rw = 1; rdst = 1; dn = 1; end
            4'd8:  begin
                       sa = 1; pcs = 2'b01; dn = 1;
                       aop = (opq == T_BEQ) ? 3'b001 : 3'b101;
                       pcw = (opq == T_BEQ) ? z : !z;
                   end
            4'd9:  begin pcs = 2'b10; pcw = 1; dn = 1; end
            4'd10: begin sa = 1; sb = 2'b10; aop = (opq == T_ADDI) ? 3'b011 : 3'b100; end
            4'd11: begin rw = 1; dn = 1; end
            default: ;
        endcase
        return {st, pcw, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, pcs, aop, dn, ill};
    endfunction

    // Drive one cycle's inputs and queue its expected outputs
    task automatic cyc(input logic [3:0] st, input logic rst, input logic mr,
                       input logic z, input logic [5:0] opc);
        exp_t e;
        reset    = rst;
        MemReady = mr;
        Zero     = z;
        OpCode   = opc;
        e.v   = model(st, rst, mr, z, opc, cur_op);
        e.ph  = phase;
        e.cyc = cycno;
        exp_q.push_back(e);
        cycno++;
        @(posedge clk);
        #1;
    endtask

    task automatic f(input logic mr);
        cyc(4'd0, 1'b0, mr, rb(), 6'($urandom));
    endtask

    task automatic d(input logic [5:0] op);
        cyc(4'd1, 1'b0, rb(), rb(), op);
        cur_op = op;
    endtask

    // Non-fetch/decode state; OpCode scrambled to prove it is ignored
    task automatic x(input logic [3:0] st, input logic mr, input logic z);
        cyc(st, 1'b0, mr, z, 6'($urandom));
    endtask

    // Monitor: compare every queued expectation at the falling edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_eq($sformatf("ph%0d_cyc%0d", e.ph, e.cyc),
                     32'({State, PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                          RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp,
                          InstrDone, IllegalOp}),
                     32'(e.v));
            if (InstrDone === 1'b1) done_seen++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; MemReady = 1'b0; Zero = 1'b0; OpCode = '0;
        @(posedge clk);
        #1;

        // Reset held, then release into FETCH with MemReady=1
        phase = 1;
        for (int i = 0; i < 3; i++) cyc(4'd0, 1'b1, 1'b1, rb(), 6'($urandom));

        // lw, no waits: 0,1,2,3,4
        phase = 2;
        f(1); d(T_LW); x(4'd2, rb(), rb()); x(4'd3, 1, rb()); x(4'd4, rb(), rb());
        done_exp++;

        // sw with two wait cycles in MEM_WR
        phase = 3;
        f(1); d(T_SW); x(4'd2, rb(), rb()); x(4'd5, 0, rb()); x(4'd5, 0, rb()); x(4'd5, 1, rb());
        done_exp++;

        // Branches, both Zero values
        phase = 4;
        f(1); d(T_BEQ); x(4'd8, rb(), 1); done_exp++;
        f(1); d(T_BNE); x(4'd8, rb(), 1); done_exp++;
        f(1); d(T_BEQ); x(4'd8, rb(), 0); done_exp++;
        f(1); d(T_BNE); x(4'd8, rb(), 0); done_exp++;

        // R-type and jump
        phase = 5;
        f(1); d(T_R); x(4'd6, rb(), rb()); x(4'd7, rb(), rb()); done_exp++;
        f(1); d(T_J); x(4'd9, rb(), rb()); done_exp++;

        // addi, slti, illegal opcode
        phase = 6;
        f(1); d(T_ADDI); x(4'd10, rb(), rb()); x(4'd11, rb(), rb()); done_exp++;
        f(1); d(T_SLTI); x(4'd10, rb(), rb()); x(4'd11, rb(), rb()); done_exp++;
        f(1); d(T_BAD);

        // Fetch wait, then lw with a MEM_RD wait
        phase = 7;
        f(0); f(0); f(1); d(T_LW); x(4'd2, rb(), rb()); x(4'd3, 0, rb()); x(4'd3, 1, rb());
        x(4'd4, rb(), rb()); done_exp++;

        // Reset asserted while in MEM_RD aborts the load
        phase = 8;
        f(1); d(T_LW); x(4'd2, rb(), rb()); x(4'd3, 0, rb());
        cyc(4'd3, 1'b1, 1'b0, rb(), 6'($urandom));
        cur_op = '0;
        f(1); d(T_ADDI); x(4'd10, rb(), rb()); x(4'd11, rb(), rb()); done_exp++;

        @(negedge clk);
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        check_eq("instr_done_count", 32'(done_seen), 32'(done_exp));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
